// File: rtl/mac_feeder.sv
// mac_feeder: buffers DEPTH FP8 operand pairs and issues them to a MAC
// over a start/done level handshake with a per-phase timeout.
module mac_feeder #(
   parameter int DEPTH = 4,
   parameter int TMO   = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [7:0]               ld_b,
   input  logic [7:0]               ld_c,
   input  logic                     start,
   input  logic                     mac_done,
   output logic                     st_mac,
   output logic [7:0]               b_out,
   output logic [7:0]               c_out,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0]    TLAST = 8'(TMO - 1);
   localparam logic [AW-1:0] ILAST = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_LOW,
      WAIT_HIGH,
      GAP,
      FINISH
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [7:0]    timer, timer_n;
   logic          st_mac_n;
   logic          err_n;
   logic [7:0]    b_n, c_n;
   logic [7:0]    buf_b [DEPTH];
   logic [7:0]    buf_c [DEPTH];
   logic          last;
   logic          expired;
   logic          wr;

   assign last    = (idx == ILAST);
   assign expired = (timer == TLAST);
   assign wr      = (state == IDLE) && load
                    && (int'(ld_addr) < DEPTH);
   assign busy    = (state != IDLE);
   assign done    = (state == FINISH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_b[i] <= '0;
            buf_c[i] <= '0;
         end
      end else if (wr) begin
         buf_b[ld_addr] <= ld_b;
         buf_c[ld_addr] <= ld_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         timer  <= '0;
         st_mac <= 1'b0;
         b_out  <= '0;
         c_out  <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         timer  <= timer_n;
         st_mac <= st_mac_n;
         b_out  <= b_n;
         c_out  <= c_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      timer_n  = timer;
      st_mac_n = st_mac;
      b_n      = b_out;
      c_n      = c_out;
      err_n    = err;
      unique case (state)
         IDLE: begin
            // a simultaneous load takes priority over start
            if (start && !load) begin
               idx_n   = '0;
               err_n   = 1'b0;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            b_n      = buf_b[idx];
            c_n      = buf_c[idx];
            st_mac_n = 1'b1;
            timer_n  = '0;
            state_n  = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!mac_done) begin
               timer_n = '0;
               state_n = WAIT_HIGH;
            end else if (expired) begin
               err_n    = 1'b1;
               st_mac_n = 1'b0;
               state_n  = IDLE;
            end else begin
               timer_n = timer + 8'd1;
            end
         end
         WAIT_HIGH: begin
            if (mac_done) begin
               st_mac_n = 1'b0;
               if (last) begin
                  state_n = FINISH;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = GAP;
               end
            end else if (expired) begin
               err_n    = 1'b1;
               st_mac_n = 1'b0;
               state_n  = IDLE;
            end else begin
               timer_n = timer + 8'd1;
            end
         end
         GAP:     state_n = ISSUE;
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: randomized bench for mac_feeder with a behavioural
// MAC model, a buffer model and a pulse/timing scoreboard.
`timescale 1ns/1ps
module tb_mac_feeder;

   localparam int DEPTH = 4;
   localparam int TMO   = 255;
   localparam int AW    = $clog2(DEPTH);
   localparam int LIM   = 2000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_b;
   logic [7:0]    ld_c;
   logic          start;
   logic          mac_done;
   logic          st_mac;
   logic [7:0]    b_out;
   logic [7:0]    c_out;
   logic          busy;
   logic          done;
   logic          err;

   mac_feeder #(.DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .ld_addr  (ld_addr),
      .ld_b     (ld_b),
      .ld_c     (ld_c),
      .start    (start),
      .mac_done (mac_done),
      .st_mac   (st_mac),
      .b_out    (b_out),
      .c_out    (c_out),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  mb [DEPTH];
   logic [7:0]  mc [DEPTH];
   logic [15:0] pul_q [$];
   int          len_q [$];
   int          gap_q [$];
   int          done_cnt = 0;
   int          hold_viol = 0;
   int          hi_cnt = 0;
   int          low_cnt = 0;
   logic        prev_st = 1'b0;
   logic [15:0] cur = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, want);
      end
   endtask

   // scoreboard of st_mac pulses seen on the falling edge
   always @(negedge clk) begin
      if (st_mac) begin
         if (!prev_st) begin
            cur = {b_out, c_out};
            pul_q.push_back(cur);
            if (len_q.size() > 0) gap_q.push_back(low_cnt);
            hi_cnt = 1;
         end else begin
            hi_cnt++;
            if ({b_out, c_out} != cur) hold_viol++;
         end
      end else begin
         if (prev_st) begin
            len_q.push_back(hi_cnt);
            low_cnt = 0;
         end
         low_cnt++;
      end
      if (done) done_cnt++;
      prev_st = st_mac;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      pul_q.delete();
      len_q.delete();
      gap_q.delete();
      done_cnt  = 0;
      hold_viol = 0;
   endtask

   task automatic do_load(input int a, input logic [7:0] b,
                          input logic [7:0] c);
      load    = 1'b1;
      ld_addr = AW'(a);
      ld_b    = b;
      ld_c    = c;
      tick();
      load = 1'b0;
      if (a < DEPTH) begin
         mb[a] = b;
         mc[a] = c;
      end
   endtask

   task automatic wait_st(input logic v, input string tag);
      int t = 0;
      while (st_mac !== v && t < LIM) begin
         tick();
         t++;
      end
      check(tag, st_mac, v);
   endtask

   // MAC model: done falls d cycles after st_mac is seen, rises r later
   task automatic serve(input int n, input int d, input int r,
                        input int rst_op);
      for (int k = 0; k < n; k++) begin
         wait_st(1'b1, "st_rise");
         repeat (d) tick();
         mac_done = 1'b0;
         if (k == rst_op) begin
            repeat (2) tick();
            rst_n = 1'b0;
            tick();
            check("rst_st", st_mac, 0);
            check("rst_bc", {b_out, c_out}, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            rst_n    = 1'b1;
            mac_done = 1'b1;
            return;
         end
         repeat (r) tick();
         mac_done = 1'b1;
         wait_st(1'b0, "st_fall");
      end
   endtask

   task automatic run(input int d, input int r, input bit xstart,
                      input bit mload);
      clear_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("err_clr", err, 0);
      check("busy_go", busy, 1);
      fork
         serve(DEPTH, d, r, -1);
         if (xstart) begin
            repeat (3) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         if (mload) begin
            repeat (5) tick();
            load    = 1'b1;
            ld_addr = AW'(2);
            ld_b    = 8'h5A;
            ld_c    = 8'hA5;
            tick();
            load = 1'b0;
         end
      join
      check("done_hi", done, 1);
      check("busy_fin", busy, 1);
      tick();
      check("done_lo", done, 0);
      check("busy_lo", busy, 0);
      check("n_pulse", pul_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < pul_q.size(); i++)
         check($sformatf("op%0d", i), pul_q[i], {mb[i], mc[i]});
      for (int i = 0; i < len_q.size(); i++)
         check($sformatf("len%0d", i), len_q[i], d + r + 1);
      check("n_gap", gap_q.size(), DEPTH - 1);
      for (int i = 0; i < gap_q.size(); i++)
         check($sformatf("gap%0d", i), gap_q[i], 2);
      check("hold", hold_viol, 0);
      check("n_done", done_cnt, 1);
      check("err_run", err, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      start    = 1'b0;
      mac_done = 1'b1;
      ld_addr  = '0;
      ld_b     = '0;
      ld_c     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mb[i] = '0;
         mc[i] = '0;
      end
      repeat (3) tick();
      check("r_st", st_mac, 0);
      check("r_b", b_out, 0);
      check("r_c", c_out, 0);
      check("r_busy", busy, 0);
      check("r_done", done, 0);
      check("r_err", err, 0);
      rst_n = 1'b1;
      tick();

      do_load(0, 8'h38, 8'h3C);
      do_load(1, 8'h40, 8'h3C);
      do_load(2, 8'h44, 8'h3C);
      do_load(3, 8'h48, 8'h3C);
      run(1, 6, 1'b0, 1'b0);

      run(20, 3, 1'b0, 1'b0);

      run(2, 2, 1'b0, 1'b1);
      run(1, 1, 1'b1, 1'b0);

      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < DEPTH; i++)
            do_load(i, 8'($urandom), 8'($urandom));
         do_load($urandom_range(0, DEPTH - 1), 8'($urandom),
                 8'($urandom));
         run($urandom_range(1, 6), $urandom_range(1, 8),
             1'($urandom_range(0, 1)), 1'b0);
      end

      clear_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_st(1'b1, "to_rise");
      repeat (TMO - 1) tick();
      check("to_err0", err, 0);
      check("to_st1", st_mac, 1);
      tick();
      check("to_err1", err, 1);
      check("to_st0", st_mac, 0);
      check("to_busy", busy, 0);
      repeat (3) tick();
      check("to_done", done_cnt, 0);
      check("to_sticky", err, 1);
      run(2, 3, 1'b0, 1'b0);

      start   = 1'b1;
      load    = 1'b1;
      ld_addr = AW'(1);
      ld_b    = 8'hC3;
      ld_c    = 8'h7E;
      tick();
      start = 1'b0;
      load  = 1'b0;
      mb[1] = 8'hC3;
      mc[1] = 8'h7E;
      check("sl_busy0", busy, 0);
      tick();
      check("sl_busy1", busy, 0);
      run(2, 3, 1'b0, 1'b0);

      clear_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      serve(DEPTH, 1, 4, 2);
      for (int i = 0; i < DEPTH; i++) begin
         mb[i] = '0;
         mc[i] = '0;
      end
      repeat (4) tick();
      check("ab_done", done_cnt, 0);
      check("ab_busy", busy, 0);
      check("ab_pulses", pul_q.size(), 3);
      run(1, 2, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
